dsp_moving_average: RTL and testbench
=====================================

// Module: dsp_moving_average
// PURPOSE
//  Boxcar moving average over the last 2**LOG2_N valid 12-bit ADC samples; the stage directly
//  upstream of dsp_detection, driving its i_data/i_valid. Running-sum architecture: one add and
//  one subtract per sample, a circular sample buffer, 1:1 throughput, 1-cycle latency.
// PARAMETERS
//  DATA_W  12  sample/output width (bits)
//  LOG2_N  3   log2 of window length N (legal 1..6; N=8 by default)
// PORTS
//  i_clk     in   1       100MHz system clock
//  i_rst     in   1       reset; one clock, reset is synchronous and active-high
//  i_data    in   DATA_W  raw ADC sample, unsigned
//  i_valid   in   1       i_data valid this cycle (no backpressure; every valid sample consumed)
//  i_clear   in   1       sync restart of averaging window (no effect on buffer contents)
//  o_data    out  DATA_W  averaged value, unsigned
//  o_valid   out  1       o_data valid, 1-cycle pulse per accepted sample once window full
//  o_primed  out  1       window holds N samples since last reset/clear
// BEHAVIOUR
//  - Reset: o_data=0, o_valid=0, o_primed=0, sum=0, wr_ptr=0, fill=0. Buffer not reset.
//  - Accept when i_valid=1: oldest = (fill==N) ? buf[wr_ptr] : 0 (masked during warm-up);
//    sum <= sum + i_data - oldest; buf[wr_ptr] <= i_data; wr_ptr <= wr_ptr+1 mod N (natural wrap);
//    fill <= min(fill+1, N), saturating.
//  - Sum width DATA_W+LOG2_N, never overflows; subtract never underflows (oldest is in sum).
//  - o_data <= sum_next >> LOG2_N, registered; o_valid <= i_valid && (fill_next==N).
//    Latency: o_valid high the cycle after the N-th accepted sample, then every cycle after an
//    accepted sample. o_data holds its last value when o_valid=0.
//  - o_primed <= (fill_next==N); stays high until reset/clear.
//  - Warm-up: samples 1..N-1 update sum/buffer but produce no o_valid.
//  - i_clear=1, i_valid=0: sum=0, fill=0, wr_ptr=0, o_valid=0, o_primed=0; o_data unchanged.
//  - i_clear=1 and i_valid=1 same cycle: clear applied first, sample becomes sample 1 of new window
//    (sum=i_data, fill=1, buf[0]=i_data, wr_ptr=1); no o_valid unless N==1... (LOG2_N>=1, so none).
//  - i_rst mid-window: all state per reset; in-flight sample discarded; i_rst dominates i_clear.
//  - Gaps in i_valid: state frozen; window is the last N valid samples, not last N cycles.
// CONFIGURATION
//  DSP_AVG_ROUND_EN defined: o_data = (sum_next + 2**(LOG2_N-1)) >> LOG2_N, round-half-up; max is
//    (N*(2**DATA_W-1) + N/2) >> LOG2_N = 2**DATA_W-1, so no saturation logic needed.
//  Undefined: truncation (floor), as above. Latency and handshake identical in both builds.
// STRUCTURE
//  - dsp_pkg: DSP_DATA_W=12, DSP_AVG_LOG2_N=3 default, shared with dsp_detection threshold width.
//  - Sub-module dsp_sample_ring: N x DATA_W buffer, wr_ptr, read-before-write of oldest sample;
//    async-read register array (N<=64), no reset on storage. Top holds sum, fill, output regs.
// TESTING (LOG2_N=3, DATA_W=12)
//  1 Reset, 8 consecutive samples of 100 -> o_valid only after 8th (cycle 9), o_data=100,
//    o_primed=1 same cycle.
//  2 Primed at 0, then 8 samples of 800 -> o_data 100,200,...,800 on successive o_valid.
//  3 Samples 1,1,1,1,0,0,0,0 -> o_data=0 (truncate) / 1 with DSP_AVG_ROUND_EN; all 4095 -> 4095
//    both builds.
//  4 Primed at 500, pulse i_clear with i_valid=1, data 40, then 7 samples of 40 -> no o_valid
//    for 7 cycles, 8th gives o_data=40 (old 500s fully excluded).
//  5 i_valid toggling 1/0 with ramp 0,10,...,150 -> o_valid only after valid cycles, o_data =
//    floor(mean of last 8 valid samples); idle cycles change nothing.
//  6 i_rst asserted after 5 samples of 300, then 8 samples of 60 -> o_valid after 8th, o_data=60,
//    no stale 300 contribution.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP front-end constants: ADC sample width and default averaging window.
// Consumed by dsp_moving_average and the downstream detection stage.
package dsp_pkg;

    localparam int DSP_DATA_W     = 12;
    localparam int DSP_AVG_LOG2_N = 3;

endpackage

// File: rtl/dsp_sample_ring.sv
// Circular N-entry sample store for the moving average; presents the oldest sample
// at the current write slot (read-before-write) so the top can retire it from the sum.
module dsp_sample_ring
    import dsp_pkg::*;
#(
    parameter int DATA_W = DSP_DATA_W,
    parameter int LOG2_N = DSP_AVG_LOG2_N
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_oldest
);

    localparam int N = 1 << LOG2_N;

    logic [DATA_W-1:0] mem [N];
    logic [LOG2_N-1:0] wr_ptr;
    logic [LOG2_N-1:0] wr_addr;

    // A clear restarts the window at slot 0, even when a sample lands in the same cycle.
    assign wr_addr  = i_clear ? '0 : wr_ptr;
    assign o_oldest = mem[wr_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
        end else if (i_wr) begin
            wr_ptr <= wr_addr + 1'b1;
        end else if (i_clear) begin
            wr_ptr <= '0;
        end
    end

    // Storage is deliberately left unreset; stale entries are masked until the window refills.
    always_ff @(posedge i_clk) begin
        if (i_wr && !i_rst) begin
            mem[wr_addr] <= i_data;
        end
    end

endmodule

// File: rtl/dsp_moving_average.sv
// Boxcar running-sum average over the last 2**LOG2_N valid samples, 1-cycle latency.
// Define DSP_AVG_ROUND_EN for round-half-up output; otherwise the output is truncated.
module dsp_moving_average
    import dsp_pkg::*;
#(
    parameter int DATA_W = DSP_DATA_W,
    parameter int LOG2_N = DSP_AVG_LOG2_N
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_primed
);

    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N:0] FILL_FULL = N[LOG2_N:0];

    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_base;
    logic [SUM_W-1:0]  sum_next;
    logic [LOG2_N:0]   fill;
    logic [LOG2_N:0]   fill_base;
    logic [LOG2_N:0]   fill_next;
    logic [DATA_W-1:0] oldest;
    logic [DATA_W-1:0] oldest_masked;
    logic [DATA_W-1:0] avg;
    logic              full_next;

    dsp_sample_ring #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (i_clear),
        .i_wr     (i_valid),
        .i_data   (i_data),
        .o_oldest (oldest)
    );

    // Clear acts before the incoming sample, so that sample opens the new window.
    always_comb begin
        sum_base      = i_clear ? '0 : sum;
        fill_base     = i_clear ? '0 : fill;
        oldest_masked = (fill_base == FILL_FULL) ? oldest : '0;
        sum_next      = sum_base;
        fill_next     = fill_base;
        if (i_valid) begin
            sum_next  = sum_base + SUM_W'(i_data) - SUM_W'(oldest_masked);
            fill_next = (fill_base == FILL_FULL) ? FILL_FULL : fill_base + 1'b1;
        end
        full_next = (fill_next == FILL_FULL);
    end

`ifdef DSP_AVG_ROUND_EN
    // The half-LSB bias cannot overflow SUM_W since the sum never exceeds N*(2**DATA_W-1).
    assign avg = DATA_W'((sum_next + SUM_W'(N / 2)) >> LOG2_N);
`else
    assign avg = DATA_W'(sum_next >> LOG2_N);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum      <= '0;
            fill     <= '0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_primed <= 1'b0;
        end else begin
            sum      <= sum_next;
            fill     <= fill_next;
            o_valid  <= i_valid && full_next;
            o_primed <= full_next;
            if (i_valid && full_next) begin
                o_data <= avg;
            end
        end
    end

endmodule

// File: tb/tb_dsp_moving_average.sv
// Scoreboard bench for dsp_moving_average (LOG2_N=3, DATA_W=12); honours DSP_AVG_ROUND_EN.
module tb_dsp_moving_average;

    localparam int DATA_W = 12;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_valid = 1'b0;
    logic              i_clear = 1'b0;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_primed;

    int n_chk  = 0;
    int n_fail = 0;

    int win[$];
    int sb[$];
    int last_data = 0;

    dsp_moving_average #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_clear  (i_clear),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_primed (o_primed)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_avg();
        int s = 0;
        foreach (win[k]) s += win[k];
`ifdef DSP_AVG_ROUND_EN
        return (s + N / 2) / N;
`else
        return s / N;
`endif
    endfunction

    // Drive one cycle, advance the reference model, then check outputs just after the edge.
    task automatic step(input logic v, input int d, input logic c, input logic r);
        int exp_v = 0;
        int exp_p = 0;
        i_valid = v;
        i_data  = DATA_W'(d);
        i_clear = c;
        i_rst   = r;
        if (r) begin
            win.delete();
            last_data = 0;
        end else begin
            if (c) win.delete();
            if (v) begin
                win.push_back(d);
                if (win.size() > N) void'(win.pop_front());
                if (win.size() == N) begin
                    exp_v     = 1;
                    last_data = model_avg();
                    sb.push_back(last_data);
                end
            end
            exp_p = (win.size() == N) ? 1 : 0;
        end
        @(posedge i_clk);
        #1;
        chk("o_valid", int'(o_valid), exp_v);
        chk("o_primed", int'(o_primed), exp_p);
        chk("o_data_hold", int'(o_data), last_data);
        if (o_valid) begin
            chk("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) chk("sb_data", int'(o_data), sb.pop_front());
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_rst   = 1'b0;
    endtask

    initial begin
        int t5_valids;

        // Reset state
        step(1'b0, 0, 1'b0, 1'b1);
        chk("rst_data", int'(o_data), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_primed", int'(o_primed), 0);

        // 1: eight samples of 100, output only after the eighth
        for (int i = 0; i < N; i++) step(1'b1, 100, 1'b0, 1'b0);
        chk("t1_avg", int'(o_data), 100);
        chk("t1_primed", int'(o_primed), 1);

        // 2: primed at zero, then a step to 800
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            step(1'b1, 800, 1'b0, 1'b0);
            chk("t2_ramp", int'(o_data), 100 * (i + 1));
        end

        // 3: rounding boundary and full scale
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, (i < 4) ? 1 : 0, 1'b0, 1'b0);
`ifdef DSP_AVG_ROUND_EN
        chk("t3_half", int'(o_data), 1);
`else
        chk("t3_half", int'(o_data), 0);
`endif
        for (int i = 0; i < N; i++) step(1'b1, 4095, 1'b0, 1'b0);
        chk("t3_max", int'(o_data), 4095);

        // 4: clear with a coincident sample restarts the window
        for (int i = 0; i < N; i++) step(1'b1, 500, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t4_clear_only_primed", int'(o_primed), 0);
        for (int i = 0; i < N; i++) step(1'b1, 500, 1'b0, 1'b0);
        step(1'b1, 40, 1'b1, 1'b0);
        for (int i = 0; i < N - 1; i++) step(1'b1, 40, 1'b0, 1'b0);
        chk("t4_avg", int'(o_data), 40);

        // 5: ramp with idle cycles between valid samples
        step(1'b0, 0, 1'b0, 1'b1);
        t5_valids = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 10 * i, 1'b0, 1'b0);
            step(1'b0, 999, 1'b0, 1'b0);
            t5_valids++;
        end
        chk("t5_avg", int'(o_data), 115);
        chk("t5_count", t5_valids, 16);

        // 6: reset mid-window discards partial sum, including an in-flight sample
        for (int i = 0; i < 5; i++) step(1'b1, 300, 1'b0, 1'b0);
        step(1'b1, 300, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, 60, 1'b0, 1'b0);
        chk("t6_avg", int'(o_data), 60);

        // Random traffic with sparse clears
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 150) == 0));
        end

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
